// File: rtl/sensor_pkg.sv
// rtl/sensor_pkg.sv - shared channel indices, level type and raw quantizer
package sensor_pkg;

  localparam int CH_RAIN    = 0;
  localparam int CH_SEISMIC = 1;
  localparam int CH_WIND    = 2;
  localparam int CH_LEVEL   = 3;

  typedef logic [1:0] level_t;

  function automatic level_t raw_level(input int unsigned d, input int unsigned t1,
                                       input int unsigned t2, input int unsigned t3);
    if (d < t1)      return 2'b00;
    else if (d < t2) return 2'b01;
    else if (d < t3) return 2'b10;
    else             return 2'b11;
  endfunction

endpackage

// File: rtl/level_debounce.sv
// rtl/level_debounce.sv - per-channel debounce of quantized levels plus idle watchdog
module level_debounce
  import sensor_pkg::*;
#(
  parameter int STABLE_CNT = 3,
  parameter int TIMEOUT    = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       acc_i,
  input  logic       q_valid_i,
  input  logic [1:0] q_i,
  output logic [1:0] code_o,
  output logic       chg_o,
  output logic       stale_o
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  level_t            cand_q, cand_d, code_q, code_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              stale_q, stale_d, chg_q;

  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    idle_d  = idle_q;
    stale_d = stale_q;

    if (acc_i) begin
      idle_d  = '0;
      stale_d = 1'b0;
    end else if (idle_q != IDLE_MAX) begin
      idle_d = idle_q + 1'b1;
    end

    if (q_valid_i) begin
      if (q_i == code_q) begin
        cand_d = code_q;
        cnt_d  = 4'd0;
      end else if (q_i == cand_q) begin
        if (4'(cnt_q + 4'd1) == 4'(STABLE_CNT)) begin
          code_d = q_i;
          cnt_d  = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end else begin
        cand_d = q_i;
        cnt_d  = 4'd1;
      end
    end

    // A sample arriving on the expiry edge keeps the channel alive.
    if (!acc_i && idle_q == IDLE_LAST) begin
      code_d  = 2'b00;
      cand_d  = 2'b00;
      cnt_d   = 4'd0;
      stale_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q  <= 2'b00;
      cnt_q   <= 4'd0;
      code_q  <= 2'b00;
      idle_q  <= '0;
      stale_q <= 1'b1;
      chg_q   <= 1'b0;
    end else begin
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      idle_q  <= idle_d;
      stale_q <= stale_d;
      chg_q   <= (code_d != code_q);
    end
  end

  assign code_o  = code_q;
  assign chg_o   = chg_q;
  assign stale_o = stale_q;

endmodule

// File: rtl/sensor_level_encoder.sv
// rtl/sensor_level_encoder.sv - quantizer stage and four debounced severity channels
module sensor_level_encoder
  import sensor_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int T1         = 64,
  parameter int T2         = 128,
  parameter int T3         = 192,
  parameter int HYST       = 8,
  parameter int STABLE_CNT = 3,
  parameter int TIMEOUT    = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [1:0]        sample_ch,
  input  logic [DATA_W-1:0] sample_data,
  output logic              r1,
  output logic              r0,
  output logic              s1,
  output logic              s0,
  output logic              w1,
  output logic              w0,
  output logic              l1,
  output logic              l0,
  output logic              code_changed,
  output logic [3:0]        stale
);

  level_t            code_w [4];
  logic [3:0]        chg_w;
  logic [DATA_W:0]   hyst_sum;
  logic [DATA_W-1:0] hyst_sat;
  level_t            raw_lvl, hyst_lvl, lvl_d, lvl_q;
  logic              valid_q;
  logic [1:0]        ch_q;

  assign hyst_sum = {1'b0, sample_data} + (DATA_W + 1)'(HYST);
  assign hyst_sat = hyst_sum[DATA_W] ? {DATA_W{1'b1}} : hyst_sum[DATA_W-1:0];
  assign raw_lvl  = raw_level(32'(sample_data), T1, T2, T3);
  assign hyst_lvl = raw_level(32'(hyst_sat), T1, T2, T3);
  // Hysteresis only applies when the sample would lower the committed code.
  assign lvl_d    = (raw_lvl < code_w[sample_ch]) ? hyst_lvl : raw_lvl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ch_q    <= 2'd0;
      lvl_q   <= 2'b00;
    end else begin
      valid_q <= sample_valid;
      ch_q    <= sample_ch;
      lvl_q   <= lvl_d;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_ch
    level_debounce #(
      .STABLE_CNT(STABLE_CNT),
      .TIMEOUT   (TIMEOUT)
    ) u_db (
      .clk      (clk),
      .rst      (rst),
      .acc_i    (sample_valid && (sample_ch == 2'(i))),
      .q_valid_i(valid_q && (ch_q == 2'(i))),
      .q_i      (lvl_q),
      .code_o   (code_w[i]),
      .chg_o    (chg_w[i]),
      .stale_o  (stale[i])
    );
  end

  assign {r1, r0}     = code_w[CH_RAIN];
  assign {s1, s0}     = code_w[CH_SEISMIC];
  assign {w1, w0}     = code_w[CH_WIND];
  assign {l1, l0}     = code_w[CH_LEVEL];
  assign code_changed = |chg_w;

endmodule

// File: tb/tb_sensor_level_encoder.sv
// tb/tb_sensor_level_encoder.sv - directed table-driven bench for sensor_level_encoder
module tb_sensor_level_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_valid = 1'b0;
  logic [1:0] sample_ch = 2'd0;
  logic [7:0] sample_data = 8'd0;
  logic       r1, r0, s1, s0, w1, w0, l1, l0;
  logic       code_changed;
  logic [3:0] stale;
  logic [7:0] codes;

  int total = 0;
  int bad   = 0;
  int pulses;

  typedef struct packed {
    logic       v;
    logic [1:0] ch;
    logic [7:0] d;
    logic [7:0] codes;
    logic       chg;
    logic [3:0] stale;
  } vec_t;

  vec_t tbl [27];

  sensor_level_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .sample_ch   (sample_ch),
    .sample_data (sample_data),
    .r1          (r1),
    .r0          (r0),
    .s1          (s1),
    .s0          (s0),
    .w1          (w1),
    .w0          (w0),
    .l1          (l1),
    .l0          (l0),
    .code_changed(code_changed),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  assign codes = {r1, r0, s1, s0, w1, w0, l1, l0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // codes = {r1r0, s1s0, w1w0, l1l0}; each row's outputs are checked after its edge
    tbl[0]  = '{1'b1, 2'd0, 8'd200, 8'h00, 1'b0, 4'b1110};
    tbl[1]  = '{1'b1, 2'd0, 8'd200, 8'h00, 1'b0, 4'b1110};
    tbl[2]  = '{1'b1, 2'd0, 8'd200, 8'h00, 1'b0, 4'b1110};
    tbl[3]  = '{1'b0, 2'd0, 8'd0,   8'hC0, 1'b1, 4'b1110};
    tbl[4]  = '{1'b0, 2'd0, 8'd0,   8'hC0, 1'b0, 4'b1110};
    tbl[5]  = '{1'b1, 2'd0, 8'd188, 8'hC0, 1'b0, 4'b1110};
    tbl[6]  = '{1'b1, 2'd0, 8'd188, 8'hC0, 1'b0, 4'b1110};
    tbl[7]  = '{1'b1, 2'd0, 8'd188, 8'hC0, 1'b0, 4'b1110};
    tbl[8]  = '{1'b0, 2'd0, 8'd0,   8'hC0, 1'b0, 4'b1110};
    tbl[9]  = '{1'b1, 2'd0, 8'd183, 8'hC0, 1'b0, 4'b1110};
    tbl[10] = '{1'b1, 2'd0, 8'd183, 8'hC0, 1'b0, 4'b1110};
    tbl[11] = '{1'b1, 2'd0, 8'd183, 8'hC0, 1'b0, 4'b1110};
    tbl[12] = '{1'b0, 2'd0, 8'd0,   8'h80, 1'b1, 4'b1110};
    tbl[13] = '{1'b0, 2'd0, 8'd0,   8'h80, 1'b0, 4'b1110};
    tbl[14] = '{1'b1, 2'd2, 8'd130, 8'h80, 1'b0, 4'b1010};
    tbl[15] = '{1'b1, 2'd2, 8'd130, 8'h80, 1'b0, 4'b1010};
    tbl[16] = '{1'b1, 2'd2, 8'd50,  8'h80, 1'b0, 4'b1010};
    tbl[17] = '{1'b1, 2'd2, 8'd130, 8'h80, 1'b0, 4'b1010};
    tbl[18] = '{1'b1, 2'd2, 8'd130, 8'h80, 1'b0, 4'b1010};
    tbl[19] = '{1'b1, 2'd2, 8'd130, 8'h80, 1'b0, 4'b1010};
    tbl[20] = '{1'b0, 2'd0, 8'd0,   8'h88, 1'b1, 4'b1010};
    tbl[21] = '{1'b0, 2'd0, 8'd0,   8'h88, 1'b0, 4'b1010};
    tbl[22] = '{1'b1, 2'd1, 8'd130, 8'h88, 1'b0, 4'b1000};
    tbl[23] = '{1'b1, 2'd1, 8'd130, 8'h88, 1'b0, 4'b1000};
    tbl[24] = '{1'b1, 2'd1, 8'd130, 8'h88, 1'b0, 4'b1000};
    tbl[25] = '{1'b0, 2'd0, 8'd0,   8'hA8, 1'b1, 4'b1000};
    tbl[26] = '{1'b0, 2'd0, 8'd0,   8'hA8, 1'b0, 4'b1000};

    repeat (3) @(negedge clk);
    check("reset_codes", 32'(codes), 32'h00);
    check("reset_chg", 32'(code_changed), 32'h0);
    check("reset_stale", 32'(stale), 32'hF);
    rst = 1'b0;

    for (int i = 0; i < 27; i++) begin
      sample_valid = tbl[i].v;
      sample_ch    = tbl[i].ch;
      sample_data  = tbl[i].d;
      @(negedge clk);
      check($sformatf("row%0d_codes", i), 32'(codes), 32'(tbl[i].codes));
      check($sformatf("row%0d_chg", i), 32'(code_changed), 32'(tbl[i].chg));
      check($sformatf("row%0d_stale", i), 32'(stale), 32'(tbl[i].stale));
    end

    // Seismic is idle 2 edges here; keep rain/wind alive so only seismic times out.
    pulses = 0;
    for (int n = 1; n <= 1002; n++) begin
      sample_valid = 1'b1;
      sample_ch    = n[0] ? 2'd0 : 2'd2;
      sample_data  = n[0] ? 8'd183 : 8'd130;
      @(negedge clk);
      pulses += int'(code_changed);
      if (n == 997) begin
        check("wd_before_codes", 32'(codes), 32'hA8);
        check("wd_before_stale1", 32'(stale[1]), 32'h0);
      end
      if (n == 998) begin
        check("wd_fire_codes", 32'(codes), 32'h88);
        check("wd_fire_stale", 32'(stale), 32'b1010);
        check("wd_fire_chg", 32'(code_changed), 32'h1);
      end
    end
    check("wd_pulse_count", 32'(pulses), 32'd1);
    check("wd_after_chg", 32'(code_changed), 32'h0);

    sample_valid = 1'b1;
    sample_ch    = 2'd3;
    sample_data  = 8'd200;
    @(negedge clk);
    @(negedge clk);
    sample_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_codes", 32'(codes), 32'h00);
    check("async_rst_chg", 32'(code_changed), 32'h0);
    check("async_rst_stale", 32'(stale), 32'hF);
    @(negedge clk);
    rst = 1'b0;

    sample_valid = 1'b1;
    sample_ch    = 2'd3;
    sample_data  = 8'd200;
    @(negedge clk);
    check("post_rst_stale", 32'(stale), 32'b0111);
    sample_valid = 1'b0;
    pulses = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      pulses += int'(code_changed);
    end
    check("post_rst_codes", 32'(codes), 32'h00);
    check("post_rst_pulses", 32'(pulses), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sensor_level_encoder.md
# sensor_level_encoder

Front-end conditioning stage that turns raw sensor samples into the debounced 2-bit severity codes (r1/r0, s1/s0, w1/w0, l1/l0) consumed by the disaster classifier/LED stage. It accepts time-multiplexed 8-bit samples from four channels (rain, seismic, wind, water level). Each sample is quantized against three thresholds with downward hysteresis. A new level is committed only after STABLE_CNT consecutive agreeing samples. A per-channel watchdog forces a silent channel to level 00 and flags it stale.

## Interface
- DATA_W, 8, raw sample width
- T1, 64, threshold for level 01
- T2, 128, threshold for level 10
- T3, 192, threshold for level 11
- HYST, 8, downward hysteresis margin
- STABLE_CNT, 3, consecutive samples required to commit (legal 2..15)
- TIMEOUT, 1000, idle cycles before a channel is declared stale
- clk  input  1  clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- sample_valid  input  1  qualifies sample_ch/sample_data for one cycle; no backpressure
- sample_ch  input  2  0 = rain, 1 = seismic, 2 = wind, 3 = level
- sample_data  input  DATA_W  raw sample
- r1, r0, s1, s0, w1, w0, l1, l0  output  1 each  committed 2-bit codes per channel
- code_changed  output  1  one-cycle pulse when any committed code changes
- stale  output  4  per-channel no-data flag, indexed by channel number

## Operation
- **Raw level:** 00 if d<T1, 01 if d<T2, 10 if d<T3, else 11.
- **Hysteresis:** let c be the committed code of the channel. If rawlevel(d) < c, use q = rawlevel(min(d+HYST, 2^DATA_W−1)); otherwise q = rawlevel(d). Compute d+HYST at DATA_W+1 bits, then saturate.
- **Per-channel debounce state:** cand[1:0], cnt[3:0], code[1:0]. On each quantized sample q:
  - q==code: cand←code, cnt←0.
  - q==cand≠code: cnt←cnt+1. If cnt+1==STABLE_CNT: code←q, cnt←0.
  - otherwise: cand←q, cnt←1.
- **Watchdog:** a per-channel idle counter clears on every accepted sample for that channel and otherwise increments.
  - When the counter reaches TIMEOUT: code←00, cand←00, cnt←0, stale[ch]←1.
  - The counter then holds until the next sample.
- stale[ch] clears on the edge that accepts a sample for that channel.
- code_changed is asserted for one cycle after any edge where any code value changes, including watchdog clears. It is not asserted when a timeout fires on a channel whose code is already 00.
- **Simultaneous events:** an accepted sample for channel ch on the cycle its idle counter would hit TIMEOUT wins. The counter clears, and no stale or clear action occurs.

## Timing
- Two-stage pipeline:
  - Sample accepted at edge k.
  - Quantized q and ch are registered at edge k (stage 1).
  - Debounce and code are updated at edge k+1.
  - Outputs reflect the update after edge k+1, and code_changed is high in the cycle following edge k+1.
- Hysteresis uses the code value at the time of stage-1 registration. Back-to-back samples on the same channel see the code before any in-flight commit. This is intentional.
- A new sample is accepted every cycle. Channels update independently.
- Watchdog clears take effect at the TIMEOUT-th idle edge, with no pipeline delay.
- **Reset (asynchronous, any time, including mid-debounce):**
  - All codes, cand, cnt, idle counters and stage-1 registers clear to 0.
  - All outputs 0 except stale = 4'b1111.
  - Any in-flight sample is discarded.

## Structure
- Shared package sensor_pkg holds:
  - channel index constants CH_RAIN=0, CH_SEISMIC=1, CH_WIND=2, CH_LEVEL=3
  - typedef level_t (2-bit)
  - the raw-level quantize function
- Sub-module level_debounce: one instance per channel, four instances. Each instance holds cand/cnt/code and the watchdog counter, and takes a q/strobe pair from the shared stage 1.
- Top level contains stage 1 (quantizer plus channel decode) and the output mapping.

## Test plan
All scenarios use default parameters.
- **Reset:** assert rst mid-run → all code outputs 0, code_changed 0, stale = 1111 immediately, with no clock required.
- **Commit:** rain samples 200, 200, 200 on consecutive cycles → r1r0 = 11 after the edge following the third acceptance; a single code_changed pulse; stale[0] = 0 after the first acceptance.
- **Hysteresis:** rain committed 11, then three samples of 188 → stays 11 (188+8 = 196 ≥ 192). Three samples of 183 → r1r0 = 10.
- **Interrupted run:** wind samples 130, 130, 50, 130, 130, 130 → w1w0 stays 00 until the sixth sample commits 10.
- **Watchdog:** seismic committed 10, then 1000 cycles with no seismic samples → s1s0 = 00, stale[1] = 1, one code_changed pulse.
- **Reset mid-debounce:** two samples of 200 on the level channel, then rst, then one more 200 → l1l0 remains 00.
